// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store unit.
package mem_access_pkg;

    // Word-address width seen by DataMem (byte address minus the two lane bits).
    localparam int WADDR_W = 6;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Latched request (the address is kept separately because its width is a parameter).
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } req_t;

    // 1 when the request is illegal for its direction or misaligned for its size.
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic is_h, is_w, illegal;
        is_h = (f3 == F3_H) || (!we && f3 == F3_HU);
        is_w = (f3 == F3_W);
        if (we) illegal = (f3 > F3_W);
        else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        return illegal || (is_h && lo[0]) || (is_w && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane datapath: load extract/extend and store merge into a captured word.
import mem_access_pkg::*;

module mem_lane #(
    parameter int NUM_LANES = 4
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            byte_off,
    input  logic [NUM_LANES*8-1:0] word,
    input  logic [31:0]           wdata,
    output logic [31:0]           load_data,
    output logic [NUM_LANES*8-1:0] store_word
);

    logic [31:0] shifted;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] wrep;

    assign shifted = word >> {byte_off, 3'b000};
    assign sel_b   = shifted[7:0];
    assign sel_h   = byte_off[1] ? word[31:16] : word[15:0];
    // Replicate store data so every candidate lane sees the right bytes.
    assign wrep    = (funct3 == F3_B) ? {4{wdata[7:0]}} : {2{wdata[15:0]}};

    // Load result selection with sign or zero extension.
    always_comb begin
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{sel_b[7]}}, sel_b};
            F3_BU:   load_data = {24'h0, sel_b};
            F3_H:    load_data = {{16{sel_h[15]}}, sel_h};
            F3_HU:   load_data = {16'h0, sel_h};
            default: load_data = word;
        endcase
    end

    // Per-byte merge: a lane takes store data when the access covers it.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic be;
        assign be = (funct3 == F3_B) ? (byte_off == 2'(k)) : (byte_off[1] == 1'(k >> 1));
        assign store_word[8*k +: 8] = be ? wrep[8*k +: 8] : word[8*k +: 8];
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the pipeline and a single-port DataMem.
import mem_access_pkg::*;

module mem_access_unit #(
    parameter int ADDR_W = WADDR_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state, state_n;
    req_t              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       rword_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              bad;
    logic [31:0]       lane_word;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign bad = req_bad(req_we, req_funct3, req_addr[1:0]);

    // In RD the live DataMem word feeds the lane logic; afterwards the captured copy does.
    assign lane_word = (state == S_RD) ? mem_rdata : rword_q;

    mem_lane u_lane (
        .funct3     (req_q.funct3),
        .byte_off   (addr_q[1:0]),
        .word       (lane_word),
        .wdata      (req_q.wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state: sw goes straight to WR, sub-word stores read first to merge.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (req_valid) begin
                if (bad)                       state_n = S_RESP;
                else if (!req_we)              state_n = S_RD;
                else if (req_funct3 == F3_W)   state_n = S_WR;
                else                           state_n = S_RD;
            end
            S_RD:   state_n = req_q.we ? S_WR : S_RESP;
            S_WR:   state_n = S_RESP;
            S_RESP: if (resp_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Request latch, read capture and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            addr_q  <= '0;
            rword_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    req_q   <= '{we: req_we, funct3: req_funct3, wdata: req_wdata};
                    addr_q  <= req_addr;
                    rdata_q <= '0;
                    err_q   <= bad;
                end
                S_RD: begin
                    rword_q <= mem_rdata;
                    if (!req_q.we) rdata_q <= load_data;
                end
                default: ;
            endcase
        end
    end

    // DataMem strobes are gated by reset so a reset during WR never writes.
    always_comb begin
        mem_read  = (state == S_RD) && !rst;
        mem_write = (state == S_WR) && !rst;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == S_RD || state == S_WR) mem_addr = addr_q[ADDR_W-1:2];
        if (state == S_WR) mem_wdata = (req_q.funct3 == F3_W) ? req_q.wdata : store_word;
    end

    assign req_ready  = (state == S_IDLE) && !rst;
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
